// File: rtl/mem_stage_lsu_if.sv
// MS stage handshake bundle: EX->MS bus, MS->WB bus, forward bus, SRAM response and flush/drop controls.
// slave = the memory stage, master = the surrounding pipeline/SRAM environment.
interface mem_stage_lsu_if #(
  parameter int DATA_W  = 32,
  parameter int SIDE_W  = 96,
  parameter int MAX_OUT = 2
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic                     ws_allowin;
  logic                     ms_allowin;
  logic                     es_to_ms_valid;
  logic [SIDE_W+DATA_W+46:0] es_to_ms_bus;
  logic                     es_drop_req;
  logic                     ms_to_ws_valid;
  logic [SIDE_W+DATA_W+38:0] ms_to_ws_bus;
  logic [DATA_W+6:0]        ms_fwd_bus;
  logic                     data_sram_data_ok;
  logic [DATA_W-1:0]        data_sram_rdata;
  logic                     ms_flush_pipe;
  logic                     ms_ex;
  logic [CNT_W-1:0]         ms_drop_cnt;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, es_drop_req,
           data_sram_data_ok, data_sram_rdata, ms_flush_pipe,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex, ms_drop_cnt
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, es_drop_req,
           data_sram_data_ok, data_sram_rdata, ms_flush_pipe,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex, ms_drop_cnt
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage (EX->WB): waits for / buffers data-SRAM responses, extracts load data, discards
// responses of flushed instructions. Optional misaligned-access exception: `define MS_ALIGN_CHECK_EN.
module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int SIDE_W  = 96,
  parameter int MAX_OUT = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_lsu_if.slave lsu
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int OFF_W = $clog2(DATA_W / 8);

  // load_op one-hot: [0]=b [1]=h [2]=w [3]=bu [4]=hu [5]=wu; stores carry their size here too
  typedef struct packed {
    logic [SIDE_W-1:0] side;
    logic              ex;
    logic              mem_req;
    logic [5:0]        load_op;
    logic              res_from_mem;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] alu_result;
    logic [31:0]       pc;
  } es_bus_t;

  es_bus_t           bus_in, bus_r;
  logic              ms_valid, buf_valid;
  logic [DATA_W-1:0] rdata_buf;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W:0]    drop_sum;

  logic              ale, ex_eff, mem_req_eff, ms_ex_w;
  logic [SIDE_W-1:0] side_eff;
  logic              own, ms_ready_go, ms_leave, cap;
  logic              inc_ms, dec;
  logic [DATA_W-1:0] src, sh, ld_data, final_result;

  assign bus_in = lsu.es_to_ms_bus;

`ifdef MS_ALIGN_CHECK_EN
  localparam logic [5:0] ECODE_ALE = 6'h09;
  logic mis_h, mis_w;
  assign mis_h = (bus_r.load_op[1] | bus_r.load_op[4]) & bus_r.alu_result[0];
  assign mis_w = (bus_r.load_op[2] | bus_r.load_op[5]) & (bus_r.alu_result[1:0] != 2'b00);
  // an older exception keeps its own ecode
  assign ale         = (mis_h | mis_w) & ~bus_r.ex;
  assign ex_eff      = bus_r.ex | ale;
  assign mem_req_eff = bus_r.mem_req & ~ale;
  assign side_eff    = ale ? {bus_r.side[SIDE_W-1:6], ECODE_ALE} : bus_r.side;
`else
  assign ale         = 1'b0;
  assign ex_eff      = bus_r.ex | ale;
  assign mem_req_eff = bus_r.mem_req;
  assign side_eff    = bus_r.side;
`endif

  // a response is ours only when no flushed request is still owed one
  assign own         = lsu.data_sram_data_ok & (drop_cnt == '0);
  assign dec         = lsu.data_sram_data_ok & (drop_cnt != '0);
  assign ms_ready_go = ~mem_req_eff | ex_eff | buf_valid | own;
  assign ms_leave    = ms_valid & ms_ready_go & lsu.ws_allowin;
  assign cap         = ms_valid & own & mem_req_eff & ~ex_eff & ~buf_valid
                       & ~(ms_ready_go & lsu.ws_allowin);
  assign inc_ms      = ms_valid & lsu.ms_flush_pipe & mem_req_eff & ~ex_eff & ~buf_valid & ~own;
  assign drop_sum    = {1'b0, drop_cnt} + (CNT_W+1)'(inc_ms) + (CNT_W+1)'(lsu.es_drop_req)
                       - (CNT_W+1)'(dec);

  assign lsu.ms_allowin = ~ms_valid | (ms_ready_go & lsu.ws_allowin);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid  <= 1'b0;
      buf_valid <= 1'b0;
      drop_cnt  <= '0;
      bus_r     <= '0;
      rdata_buf <= '0;
    end else begin
      if (lsu.ms_flush_pipe)   ms_valid <= 1'b0;
      else if (lsu.ms_allowin) ms_valid <= lsu.es_to_ms_valid;

      if (lsu.es_to_ms_valid && lsu.ms_allowin) bus_r <= bus_in;

      if (lsu.ms_flush_pipe || ms_leave) begin
        buf_valid <= 1'b0;
      end else if (cap) begin
        buf_valid <= 1'b1;
        rdata_buf <= lsu.data_sram_rdata;
      end

      drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

  // load extraction: shift the addressed byte lane down, then size/sign-extend
  assign src = buf_valid ? rdata_buf : lsu.data_sram_rdata;
  assign sh  = src >> {bus_r.alu_result[OFF_W-1:0], 3'b000};

  always_comb begin
    ld_data = '0;
    if (bus_r.load_op[0]) ld_data = DATA_W'($signed(sh[7:0]));
    if (bus_r.load_op[1]) ld_data = DATA_W'($signed(sh[15:0]));
    if (bus_r.load_op[2]) ld_data = DATA_W'($signed(sh[31:0]));
    if (bus_r.load_op[3]) ld_data = DATA_W'(sh[7:0]);
    if (bus_r.load_op[4]) ld_data = DATA_W'(sh[15:0]);
    if (bus_r.load_op[5]) ld_data = DATA_W'(sh[31:0]);
  end

  assign final_result = bus_r.res_from_mem ? ld_data : bus_r.alu_result;
  assign ms_ex_w      = ms_valid & ex_eff;

  assign lsu.ms_ex          = ms_ex_w;
  assign lsu.ms_to_ws_valid = ms_valid & ms_ready_go & ~lsu.ms_flush_pipe;
  assign lsu.ms_to_ws_bus   = {side_eff, ms_ex_w, bus_r.gr_we, bus_r.dest, final_result, bus_r.pc};
  assign lsu.ms_fwd_bus     = {ms_valid & bus_r.res_from_mem & ~ms_ready_go,
                               ms_valid & bus_r.gr_we, bus_r.dest, final_result};
  assign lsu.ms_drop_cnt    = drop_cnt;

  // more outstanding flushed requests than the SRAM can hold is an upstream protocol error
  assert property (@(posedge clk) disable iff (reset) drop_sum <= (CNT_W+1)'(MAX_OUT));
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: 32-bit and 64-bit instances, hand-computed expectations.
module tb_mem_stage_lsu;
  localparam int SIDE_W = 96;
  localparam logic [5:0] OP_B = 6'b000001, OP_H = 6'b000010, OP_W = 6'b000100,
                         OP_BU = 6'b001000, OP_HU = 6'b010000, OP_WU = 6'b100000;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.DATA_W(32), .SIDE_W(SIDE_W), .MAX_OUT(2)) i32 ();
  mem_stage_lsu_if #(.DATA_W(64), .SIDE_W(SIDE_W), .MAX_OUT(2)) i64 ();

  mem_stage_lsu #(.DATA_W(32), .SIDE_W(SIDE_W), .MAX_OUT(2)) dut32 (.clk(clk), .reset(reset), .lsu(i32));
  mem_stage_lsu #(.DATA_W(64), .SIDE_W(SIDE_W), .MAX_OUT(2)) dut64 (.clk(clk), .reset(reset), .lsu(i64));

  wire [31:0] res32   = i32.ms_to_ws_bus[63:32];
  wire [63:0] res64   = i64.ms_to_ws_bus[95:32];
  wire [5:0]  ecode32 = i32.ms_to_ws_bus[76:71];
  wire        bex32   = i32.ms_to_ws_bus[70];
  wire        pend32  = i32.ms_fwd_bus[38];
  wire        fv32    = i32.ms_fwd_bus[37];
  wire [4:0]  fdst32  = i32.ms_fwd_bus[36:32];

  function automatic logic [SIDE_W+32+46:0] bus32(input logic ex, mreq, input logic [5:0] op,
      input logic rfm, we, input logic [4:0] dest, input logic [31:0] alu, pc);
    return {{SIDE_W{1'b0}}, ex, mreq, op, rfm, we, dest, alu, pc};
  endfunction

  function automatic logic [SIDE_W+64+46:0] bus64(input logic [5:0] op, input logic [63:0] alu);
    return {{SIDE_W{1'b0}}, 1'b0, 1'b1, op, 1'b1, 1'b1, 5'd9, alu, 32'h1c00_0100};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    i32.ws_allowin = 1'b1; i32.es_to_ms_valid = 1'b0; i32.es_to_ms_bus = '0; i32.es_drop_req = 1'b0;
    i32.data_sram_data_ok = 1'b0; i32.data_sram_rdata = '0; i32.ms_flush_pipe = 1'b0;
    i64.ws_allowin = 1'b1; i64.es_to_ms_valid = 1'b0; i64.es_to_ms_bus = '0; i64.es_drop_req = 1'b0;
    i64.data_sram_data_ok = 1'b0; i64.data_sram_rdata = '0; i64.ms_flush_pipe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (i32.ms_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got %0h exp 1", i32.ms_allowin); end
    checks++; if (i32.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", i32.ms_to_ws_valid); end
    checks++; if (i32.ms_drop_cnt !== 2'd0) begin errors++; $display("FAIL rst_drop got %0h exp 0", i32.ms_drop_cnt); end
    checks++; if (i32.ms_fwd_bus !== '0) begin errors++; $display("FAIL rst_fwd got %0h exp 0", i32.ms_fwd_bus); end
    checks++; if (i32.ms_to_ws_bus !== '0 || i32.ms_ex !== 1'b0) begin errors++; $display("FAIL rst_bus got %0h ex %0h exp 0", i32.ms_to_ws_bus, i32.ms_ex); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ld_b_same_cycle();
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b0, 1'b1, OP_B, 1'b1, 1'b1, 5'd5, 32'h0000_1003, 32'h1c00_0000);
    step();
    i32.es_to_ms_valid = 1'b0; i32.data_sram_data_ok = 1'b1; i32.data_sram_rdata = 32'h80FF_1234;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid got %0h exp 1", i32.ms_to_ws_valid); end
    checks++; if (res32 !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_result got %h exp ffffff80", res32); end
    checks++; if (pend32 !== 1'b0 || fv32 !== 1'b1 || fdst32 !== 5'd5) begin errors++; $display("FAIL ldb_fwd got p%0h v%0h d%0d exp p0 v1 d5", pend32, fv32, fdst32); end
    step();
    i32.data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL ldb_drain got %0h exp 0", i32.ms_to_ws_valid); end
    step();
  endtask

  task automatic test_ld_hu_late_buffered();
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b0, 1'b1, OP_HU, 1'b1, 1'b1, 5'd7, 32'h0000_2002, 32'h1c00_0010);
    step();
    i32.es_to_ms_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (pend32 !== 1'b1 || i32.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL hu_wait%0d got p%0h v%0h exp p1 v0", c, pend32, i32.ms_to_ws_valid); end
      step();
    end
    i32.ws_allowin = 1'b0; i32.data_sram_data_ok = 1'b1; i32.data_sram_rdata = 32'hBEEF_0000;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b1 || i32.ms_allowin !== 1'b0 || pend32 !== 1'b0) begin errors++; $display("FAIL hu_dok got v%0h a%0h p%0h exp v1 a0 p0", i32.ms_to_ws_valid, i32.ms_allowin, pend32); end
    step();
    i32.data_sram_data_ok = 1'b0; i32.data_sram_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    checks++; if (res32 !== 32'h0000_BEEF || i32.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL hu_buf got %h v%0h exp 0000beef v1", res32, i32.ms_to_ws_valid); end
    step();
    i32.ws_allowin = 1'b1;
    @(negedge clk);
    checks++; if (res32 !== 32'h0000_BEEF || i32.ms_allowin !== 1'b1) begin errors++; $display("FAIL hu_out got %h a%0h exp 0000beef a1", res32, i32.ms_allowin); end
    step();
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL hu_drain got %0h exp 0", i32.ms_to_ws_valid); end
    step();
  endtask

  task automatic test_flush_drop();
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b0, 1'b1, OP_W, 1'b1, 1'b1, 5'd2, 32'h0000_3000, 32'h1c00_0020);
    step();
    i32.es_to_ms_valid = 1'b0; i32.ms_flush_pipe = 1'b1;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0h exp 0", i32.ms_to_ws_valid); end
    step();
    i32.ms_flush_pipe = 1'b0;
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b0, 1'b1, OP_W, 1'b1, 1'b1, 5'd3, 32'h0000_4000, 32'h1c00_0024);
    @(negedge clk);
    checks++; if (i32.ms_drop_cnt !== 2'd1 || i32.ms_allowin !== 1'b1) begin errors++; $display("FAIL fl_cnt1 got %0d a%0h exp 1 a1", i32.ms_drop_cnt, i32.ms_allowin); end
    step();
    i32.es_to_ms_valid = 1'b0; i32.data_sram_data_ok = 1'b1; i32.data_sram_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b0 || pend32 !== 1'b1) begin errors++; $display("FAIL fl_stale got v%0h p%0h exp v0 p1", i32.ms_to_ws_valid, pend32); end
    step();
    i32.data_sram_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (i32.ms_drop_cnt !== 2'd0) begin errors++; $display("FAIL fl_cnt0 got %0d exp 0", i32.ms_drop_cnt); end
    checks++; if (i32.ms_to_ws_valid !== 1'b1 || res32 !== 32'h1234_5678) begin errors++; $display("FAIL fl_new got v%0h %h exp v1 12345678", i32.ms_to_ws_valid, res32); end
    step();
    i32.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_drop_two();
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b0, 1'b1, OP_W, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h1c00_0030);
    step();
    i32.es_to_ms_valid = 1'b0; i32.ms_flush_pipe = 1'b1; i32.es_drop_req = 1'b1;
    step();
    i32.ms_flush_pipe = 1'b0; i32.es_drop_req = 1'b0; i32.data_sram_data_ok = 1'b1;
    @(negedge clk);
    checks++; if (i32.ms_drop_cnt !== 2'd2) begin errors++; $display("FAIL d2_cnt2 got %0d exp 2", i32.ms_drop_cnt); end
    step();
    @(negedge clk);
    checks++; if (i32.ms_drop_cnt !== 2'd1 || i32.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL d2_cnt1 got %0d v%0h exp 1 v0", i32.ms_drop_cnt, i32.ms_to_ws_valid); end
    step();
    i32.data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++; if (i32.ms_drop_cnt !== 2'd0) begin errors++; $display("FAIL d2_cnt0 got %0d exp 0", i32.ms_drop_cnt); end
    step();
  endtask

  task automatic test_store();
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b0, 1'b1, OP_W, 1'b0, 1'b0, 5'd0, 32'h0000_6004, 32'h1c00_0040);
    step();
    i32.es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b0 || pend32 !== 1'b0) begin errors++; $display("FAIL st_wait got v%0h p%0h exp v0 p0", i32.ms_to_ws_valid, pend32); end
    step();
    i32.data_sram_data_ok = 1'b1; i32.data_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b1 || res32 !== 32'h0000_6004 || fv32 !== 1'b0) begin errors++; $display("FAIL st_done got v%0h %h fv%0h exp v1 00006004 fv0", i32.ms_to_ws_valid, res32, fv32); end
    step();
    i32.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 5'd3, 32'h0000_0011, 32'h1c00_0050);
    step();
    i32.es_to_ms_bus   = bus32(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 5'd4, 32'h0000_0022, 32'h1c00_0054);
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b1 || res32 !== 32'h11 || fdst32 !== 5'd3 || i32.ms_allowin !== 1'b1) begin errors++; $display("FAIL b2b_1 got v%0h %h d%0d exp v1 11 d3", i32.ms_to_ws_valid, res32, fdst32); end
    step();
    i32.es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b1 || res32 !== 32'h22 || fdst32 !== 5'd4) begin errors++; $display("FAIL b2b_2 got v%0h %h d%0d exp v1 22 d4", i32.ms_to_ws_valid, res32, fdst32); end
    step();
  endtask

  task automatic test_ex_passthrough();
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b1, 1'b1, OP_W, 1'b1, 1'b0, 5'd0, 32'h0000_7000, 32'h1c00_0060);
    step();
    i32.es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (i32.ms_ex !== 1'b1 || bex32 !== 1'b1 || i32.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL ex_pass got ex%0h b%0h v%0h exp 1 1 1", i32.ms_ex, bex32, i32.ms_to_ws_valid); end
    step();
  endtask

  task automatic test_wide64();
    i64.es_to_ms_valid = 1'b1; i64.es_to_ms_bus = bus64(OP_WU, 64'h0000_0000_0000_8004);
    step();
    i64.es_to_ms_bus = bus64(OP_W, 64'h0000_0000_0000_8004);
    i64.data_sram_data_ok = 1'b1; i64.data_sram_rdata = 64'h8000_0001_0000_0000;
    @(negedge clk);
    checks++; if (i64.ms_to_ws_valid !== 1'b1 || res64 !== 64'h0000_0000_8000_0001) begin errors++; $display("FAIL w64_wu got v%0h %h exp v1 0000000080000001", i64.ms_to_ws_valid, res64); end
    step();
    i64.es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (i64.ms_to_ws_valid !== 1'b1 || res64 !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL w64_w got v%0h %h exp v1 ffffffff80000001", i64.ms_to_ws_valid, res64); end
    step();
    i64.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_align();
    i32.es_to_ms_valid = 1'b1;
    i32.es_to_ms_bus   = bus32(1'b0, 1'b1, OP_W, 1'b1, 1'b1, 5'd6, 32'h0000_1002, 32'h1c00_0070);
    step();
    i32.es_to_ms_valid = 1'b0;
    @(negedge clk);
`ifdef MS_ALIGN_CHECK_EN
    checks++; if (i32.ms_ex !== 1'b1 || ecode32 !== 6'h09 || i32.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL ale got ex%0h ec%0h v%0h exp 1 09 1", i32.ms_ex, ecode32, i32.ms_to_ws_valid); end
    step();
`else
    checks++; if (i32.ms_ex !== 1'b0 || ecode32 !== 6'h00 || i32.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL noale got ex%0h ec%0h v%0h exp 0 00 0", i32.ms_ex, ecode32, i32.ms_to_ws_valid); end
    step();
    i32.data_sram_data_ok = 1'b1;
    @(negedge clk);
    checks++; if (i32.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL noale_done got %0h exp 1", i32.ms_to_ws_valid); end
    step();
    i32.data_sram_data_ok = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    i32.es_drop_req = 1'b1;
    step();
    i32.es_drop_req = 1'b0;
    @(negedge clk);
    checks++; if (i32.ms_drop_cnt !== 2'd1) begin errors++; $display("FAIL rm_pre got %0d exp 1", i32.ms_drop_cnt); end
    #1 reset = 1'b1;
    #1;
    checks++; if (i32.ms_drop_cnt !== 2'd0) begin errors++; $display("FAIL rm_clr got %0d exp 0", i32.ms_drop_cnt); end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_ld_b_same_cycle();
    test_ld_hu_late_buffered();
    test_flush_drop();
    test_drop_two();
    test_store();
    test_back_to_back();
    test_ex_passthrough();
    test_wide64();
    test_align();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the pipeline's memory stage.
- Sits between EX and WB. It waits for the data-SRAM response of a load or store accepted in EX, buffers that response while WB stalls, extracts load data for DATA_W = 32 or 64, and drives the MS forward bus.
- Tracks SRAM responses that belong to flushed instructions and discards them, so a stale data_ok never completes a younger instruction.

Parameters:
- DATA_W, 32, datapath and SRAM data width; legal values 32 or 64.
- SIDE_W, 96, width of the opaque sideband (CSR/exception fields) carried unchanged EX→WB.
- MAX_OUT, 2, maximum number of SRAM requests in flight that may be dropped; sizes the drop counter at clog2(MAX_OUT+1) bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MS can accept
- es_to_ms_valid  in  1  EX output valid
- es_to_ms_bus  in  SIDE_W+DATA_W+47  {side, ex, mem_req, load_op[5:0], res_from_mem, gr_we, dest[4:0], alu_result[DATA_W-1:0], pc[31:0]}
- es_drop_req  in  1  pulse: EX discarded an instruction whose SRAM request was already accepted
- ms_to_ws_valid  out  1  MS output valid
- ms_to_ws_bus  out  SIDE_W+DATA_W+39  {side, ms_ex, gr_we, dest, final_result, pc}
- ms_fwd_bus  out  DATA_W+7  {ms_data_pending, fwd_valid, dest, final_result}
- data_sram_data_ok  in  1  SRAM response strobe
- data_sram_rdata  in  DATA_W  SRAM read data
- ms_flush_pipe  in  1  pipeline flush (exception or ertn)
- ms_ex  out  1  valid instruction carrying an exception
- ms_drop_cnt  out  clog2(MAX_OUT+1)  pending responses still to be discarded (debug)

Behaviour:
- Reset values (asynchronous): ms_valid=0, buf_valid=0, drop_cnt=0, bus register=0. All outputs therefore reset low or zero, and ms_allowin=1.
- Acceptance: the bus register loads when es_to_ms_valid & ms_allowin. ms_valid loads es_to_ms_valid whenever ms_allowin.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- Response ownership:
  - data_ok with drop_cnt>0 decrements drop_cnt and is discarded.
  - data_ok with drop_cnt==0 belongs to the MS instruction.
  - drop_cnt never exceeds MAX_OUT; exceeding it is a protocol error (assertion).
- Response buffering: data_ok owned by MS while not (ms_ready_go & ws_allowin) captures rdata into rdata_buf and sets buf_valid. buf_valid clears when the instruction leaves MS or is flushed.
- ms_ready_go = !mem_req | ex | buf_valid | (data_ok & drop_cnt==0). Latency: 0 extra cycles if data_ok arrives in the first MS cycle; otherwise MS stalls until data_ok.
- Stores (mem_req=1, res_from_mem=0) also wait for data_ok.
- load_op is one-hot: b, h, w, bu, hu, wu. Byte lane = alu_result[log2(DATA_W/8)-1:0].
  - b, h, w sign-extend to DATA_W.
  - bu, hu, wu zero-extend to DATA_W.
  - For DATA_W=32, w and wu are identical.
  - Data source is rdata_buf when buf_valid, otherwise data_sram_rdata.
- final_result = res_from_mem ? extracted load data : alu_result.
- Flush:
  - ms_to_ws_valid = ms_valid & ms_ready_go & !ms_flush_pipe. ms_valid clears on the next edge.
  - If the flushed instruction has mem_req & !ex & !buf_valid & !(data_ok this cycle owned), drop_cnt increments.
  - es_drop_req also increments drop_cnt.
  - Simultaneous increments and a decrement in the same cycle net out: drop_cnt += inc_ms + inc_es − dec.
- Forwarding:
  - fwd_valid = ms_valid & gr_we.
  - ms_data_pending = ms_valid & res_from_mem & !ms_ready_go. EX/ID must stall on this bit and must not forward.
- ms_ex = ms_valid & ex.
- Reset mid-transaction clears drop_cnt; the SRAM is reset on the same reset.

Optional Feature:
- MS_ALIGN_CHECK_EN
- Defined:
  - A load or store whose alu_result is misaligned for its access size raises ms_ex, with side ecode replaced by 0x09 (ALE) and mem_req treated as 0.
  - EX guarantees no SRAM request is issued for such an access.
- Undefined: no alignment check; ms_ex reflects only the incoming ex bit.

Test Plan:
- DATA_W=32, ld.b at alu_result=0x1003, data_ok in the same cycle with rdata=0x80FF_1234 → final_result=0xFFFF_FF80, ms_to_ws_valid in the same cycle.
- ld.hu, data_ok 3 cycles late with ws_allowin=0 for 2 further cycles, rdata=0xBEEF_0000 at offset 2 → ms_data_pending=1 until data_ok; buffered result 0x0000_BEEF presented once ws_allowin=1.
- Flush while a load waits for data → drop_cnt=1. The next load is accepted and the old data_ok is discarded (drop_cnt→0). The second data_ok (0x1234_5678, ld.w) completes the new load with 0x1234_5678.
- es_drop_req pulse and MS flush in the same cycle, with no data_ok → drop_cnt=2; two later data_oks are both discarded.
- DATA_W=64, ld.wu at offset 4 with rdata=0x8000_0001_0000_0000 → final_result=0x0000_0000_8000_0001.
- MS_ALIGN_CHECK_EN, ld.w at 0x1002 → ms_ex=1, ecode 0x09, no wait for data_ok.
